// File: rtl/scan_decoder_if.sv
// scan_decoder_if -- control/status bundle for scan_decoder.
//   master : drives clr, load, mode, sel, en, dir; observes onehot, idx, valid, wrap
//   slave  : the decoder itself (inverse directions)
// N is the select width; OUTS = 2**N one-hot outputs.
interface scan_decoder_if #(
  parameter int N = 2
);
  localparam int OUTS = 2 ** N;

  logic            clr;
  logic            load;
  logic            mode;
  logic [N-1:0]    sel;
  logic            en;
  logic            dir;
  logic [OUTS-1:0] onehot;
  logic [N-1:0]    idx;
  logic            valid;
  logic            wrap;

  modport master (
    output clr, load, mode, sel, en, dir,
    input  onehot, idx, valid, wrap
  );

  modport slave (
    input  clr, load, mode, sel, en, dir,
    output onehot, idx, valid, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// scan_decoder -- registered N-to-2**N one-hot decoder with optional scan mode.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (forces IDLE, all outputs zero)
//   bus  : scan_decoder_if.slave
//          clr  - synchronous clear to IDLE (highest priority)
//          load - capture sel/mode; mode=0 static decode, mode=1 scan
//          en   - advance scan by one position per edge (SCAN only)
//          dir  - 0 = step up, 1 = step down (modulo OUTS)
//          onehot/idx/valid/wrap - registered outputs; wrap pulses for the
//          cycle after a scan wraps around
module scan_decoder #(
  parameter int N = 2
) (
  input  logic          clk,
  input  logic          rst,
  scan_decoder_if.slave bus
);
  localparam int OUTS = 2 ** N;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  logic [1:0]      state_q,  state_n;
  logic [N-1:0]    idx_q,    idx_n;
  logic            valid_q,  valid_n;
  logic            wrap_q,   wrap_n;
  logic [OUTS-1:0] onehot_q, onehot_n;

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    wrap_n  = 1'b0;

    if (bus.clr) begin
      state_n = IDLE;
      idx_n   = '0;
      valid_n = 1'b0;
    end else if (bus.load) begin
      state_n = bus.mode ? SCAN : DECODE;
      idx_n   = bus.sel;
      valid_n = 1'b1;
    end else if (state_q == SCAN && bus.en) begin
      // N-bit add/subtract wraps naturally modulo OUTS
      if (!bus.dir) begin
        idx_n  = idx_q + 1'b1;
        wrap_n = (idx_q == '1);
      end else begin
        idx_n  = idx_q - 1'b1;
        wrap_n = (idx_q == '0);
      end
    end

    // one-hot is derived from the next index so it is registered alongside it
    onehot_n = '0;
    if (valid_n) onehot_n[idx_n] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      valid_q  <= valid_n;
      wrap_q   <= wrap_n;
      onehot_q <= onehot_n;
    end
  end

  assign bus.onehot = onehot_q;
  assign bus.idx    = idx_q;
  assign bus.valid  = valid_q;
  assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder -- self-checking bench for scan_decoder (N=2).
// Directed sequences for static decode, up/down scan, priority and async
// reset, then randomized stimulus against a behavioural reference model.
module tb_scan_decoder;
  localparam int N    = 2;
  localparam int OUTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  scan_decoder_if #(.N(N)) bus ();

  scan_decoder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: "scanning" flag plus integer position
  bit m_valid;
  bit m_scan;
  int m_idx;
  bit m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_scan = 0; m_idx = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    if (rst || bus.clr) begin
      model_reset();
    end else if (bus.load) begin
      m_valid = 1; m_scan = bus.mode; m_idx = int'(bus.sel); m_wrap = 0;
    end else if (m_scan && bus.en) begin
      if (!bus.dir) begin
        m_wrap = (m_idx == OUTS - 1);
        m_idx  = (m_idx + 1) % OUTS;
      end else begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + OUTS - 1) % OUTS;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic check_model(input string tag);
    int exp_oh;
    exp_oh = m_valid ? (1 << m_idx) : 0;
    check({tag, ".onehot"}, 32'(bus.onehot), 32'(exp_oh));
    check({tag, ".idx"},    32'(bus.idx),    32'(m_idx));
    check({tag, ".valid"},  32'(bus.valid),  32'(m_valid));
    check({tag, ".wrap"},   32'(bus.wrap),   32'(m_wrap));
    check({tag, ".inv"}, 32'(bus.onehot),
          32'(bus.valid ? (1 << int'(bus.idx)) : 0));
  endtask

  // one clock: model follows the edge, outputs sampled 1 time unit later
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input bit c, input bit l, input bit m, input int s,
                       input bit e, input bit d);
    bus.clr = c; bus.load = l; bus.mode = m; bus.sel = N'(s);
    bus.en = e; bus.dir = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp33_idx[5]  = '{2, 3, 0, 1, 2};
    int exp33_wrap[5] = '{0, 0, 1, 0, 0};
    int exp34_idx[6]  = '{1, 0, 3, 3, 3, 2};
    int exp34_wrap[6] = '{0, 0, 1, 0, 0, 0};
    int exp34_en[5]   = '{1, 1, 0, 0, 1};

    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("reset.onehot", 32'(bus.onehot), 32'd0);
    check("reset.valid",  32'(bus.valid),  32'd0);
    #12;
    rst = 1'b0;
    #2;

    // idle ignores en/dir
    drive(0, 0, 0, 0, 1, 1);
    tick("idle");
    check("idle.valid", 32'(bus.valid), 32'd0);

    // static decode sel 0..3 on successive cycles
    for (int s = 0; s < OUTS; s++) begin
      drive(0, 1, 0, s, 0, 0);
      tick("decode");
      check("decode.onehot_const", 32'(bus.onehot), 32'(1 << s));
      check("decode.valid_const",  32'(bus.valid),  32'd1);
    end
    // decode holds with en/dir toggling
    drive(0, 0, 0, 0, 1, 0); tick("decode_hold");
    drive(0, 0, 0, 0, 1, 1); tick("decode_hold");
    check("decode_hold.idx", 32'(bus.idx), 32'd3);

    // up scan from 2 with wrap
    drive(0, 1, 1, 2, 1, 0);
    tick("up");
    check("up.idx_const", 32'(bus.idx), 32'(exp33_idx[0]));
    check("up.wrap_const", 32'(bus.wrap), 32'(exp33_wrap[0]));
    for (int i = 1; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      tick("up");
      check("up.idx_const",  32'(bus.idx),  32'(exp33_idx[i]));
      check("up.wrap_const", 32'(bus.wrap), 32'(exp33_wrap[i]));
    end

    // down scan with hold
    drive(0, 1, 1, 1, 0, 1);
    tick("down");
    check("down.idx_const", 32'(bus.idx), 32'(exp34_idx[0]));
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, exp34_en[i] != 0, 1);
      tick("down");
      check("down.idx_const",  32'(bus.idx),  32'(exp34_idx[i+1]));
      check("down.wrap_const", 32'(bus.wrap), 32'(exp34_wrap[i+1]));
    end

    // priority: clr beats load and en
    drive(1, 1, 1, 2, 1, 0);
    tick("prio_clr");
    check("prio_clr.onehot_const", 32'(bus.onehot), 32'd0);
    // load beats en: no advance in the load cycle
    drive(0, 1, 1, 3, 1, 0);
    tick("prio_load");
    check("prio_load.idx_const", 32'(bus.idx), 32'd3);
    check("prio_load.wrap_const", 32'(bus.wrap), 32'd0);

    // async reset mid-scan at idx=2
    drive(0, 1, 1, 2, 0, 0);
    tick("pre_rst");
    check("pre_rst.idx_const", 32'(bus.idx), 32'd2);
    drive(0, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst.onehot", 32'(bus.onehot), 32'd0);
    check("async_rst.idx",    32'(bus.idx),    32'd0);
    check("async_rst.valid",  32'(bus.valid),  32'd0);
    drive(0, 1, 1, 1, 1, 0);            // ignored while rst high
    tick("in_rst");
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    tick("post_rst");
    tick("post_rst");
    check("post_rst.valid_const", 32'(bus.valid), 32'd0);

    // randomized stimulus
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0,
            $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) != 0,
            int'($urandom_range(0, OUTS - 1)),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 1) != 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 The block SHALL take parameter N, default 2, select width in bits; legal range 1..6.
REQ-002 The block SHALL derive localparam OUTS = 2**N, the number of one-hot outputs (default 4).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port clr  input  1  synchronous clear to IDLE.
REQ-006 The block SHALL have port load  input  1  start strobe; captures sel and mode.
REQ-007 The block SHALL have port mode  input  1  0 = static decode, 1 = scan.
REQ-008 The block SHALL have port sel  input  N  start/decode index.
REQ-009 The block SHALL have port en  input  1  scan advance enable.
REQ-010 The block SHALL have port dir  input  1  scan direction: 0 = up, 1 = down.
REQ-011 The block SHALL have port onehot  output  OUTS  registered one-hot outputs; bit i set = output i active.
REQ-012 The block SHALL have port idx  output  N  registered index of the active output.
REQ-013 The block SHALL have port valid  output  1  high while onehot holds a valid code.
REQ-014 The block SHALL have port wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-015 The block SHALL implement states IDLE, DECODE, SCAN; all outputs registered; no combinational input-to-output path.
REQ-016 Control priority SHALL be clr > load > en; lower-priority inputs are ignored in a cycle where a higher one is asserted.
REQ-017 clr=1 SHALL, at the next edge, enter IDLE with onehot=0, idx=0, valid=0, wrap=0, from any state.
REQ-018 In IDLE, with clr=0 and load=0, all outputs SHALL hold zero; en and dir are ignored.
REQ-019 load=1 with mode=0 SHALL, one cycle later, give idx=sel, onehot=1<<sel, valid=1, wrap=0, state DECODE.
REQ-020 In DECODE, outputs SHALL hold unchanged regardless of en/dir until clr or load.
REQ-021 load=1 with mode=1 SHALL, one cycle later, give idx=sel, onehot=1<<sel, valid=1, wrap=0, state SCAN; no advance in the load cycle even if en=1.
REQ-022 In SCAN with en=1, idx SHALL step by +1 (dir=0) or -1 (dir=1) modulo OUTS each edge; onehot SHALL always equal 1<<idx.
REQ-023 In SCAN with en=0, idx and onehot SHALL hold and wrap SHALL be 0.
REQ-024 wrap SHALL be 1 for exactly the cycle after an up-step from OUTS-1 to 0 or a down-step from 0 to OUTS-1, and 0 otherwise.
REQ-025 dir MAY change on any cycle; each step SHALL use the dir value sampled at that edge.
REQ-026 load during DECODE or SCAN SHALL restart per REQ-019/021 with the new sel and mode; wrap SHALL be 0 that cycle.
REQ-027 For N=1 the scan SHALL alternate between outputs 0 and 1, with wrap asserted on every 1->0 step (up) or every 0->1 step (down).
REQ-028 onehot SHALL never have more than one bit set; valid=1 SHALL imply exactly one bit set.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force IDLE, onehot=0, idx=0, valid=0, wrap=0.
REQ-030 While rst=1, all inputs SHALL be ignored; after rst deasserts, the first edge SHALL act on the inputs present then.
REQ-031 rst asserted mid-scan SHALL abort the scan; the scan SHALL NOT resume after deassertion without a new load.

Verification (N=2)
REQ-032 Static decode: load=1, mode=0, sel=0..3 on successive cycles -> onehot 0001, 0010, 0100, 1000, each one cycle after its load; valid=1.
REQ-033 Up scan with wrap: load, mode=1, sel=2, then en=1, dir=0 for 4 cycles -> idx 2,3,0,1,2; wrap=1 only in the cycle idx=0.
REQ-034 Down scan with hold: start sel=1, en=1, dir=1 for 2 cycles, en=0 for 2 cycles, en=1 for 1 cycle -> idx 1,0,3,3,3,2; wrap=1 only in the cycle idx first becomes 3.
REQ-035 Priority: clr=1, load=1, en=1 in the same cycle during SCAN -> IDLE, all outputs 0; load=1, en=1 with mode=1, sel=3 -> idx=3, no advance.
REQ-036 Async reset mid-scan: rst pulsed between clock edges while idx=2 -> outputs 0 before the next edge; en=1 after release -> outputs stay 0 until a load.
REQ-037 Invariant check across random stimulus: onehot == (valid ? 1<<idx : 0) every cycle.
